psum_accum_ctrl: RTL

Sequencer for the PL side of the psum BRAM bus mux. It performs partial-sum read-modify-write accumulation from the PE array onto the shared single-port psum BRAM. It provides a range-clear engine for the start of each output tile. It arbitrates BRAM ownership between the PL datapath and the PS AXI BRAM controller. It drives the mux's PL `mem_*` bus and its ownership select.

---
 rtl/psum_pkg.sv | 22 ++
 rtl/psum_sat_add.sv | 30 +++
 rtl/psum_accum_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared types and constants for the psum accumulation sequencer.
// The FSM encoding, saturation limits and index-to-byte-address shift live here.
package psum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_CLR,
        ST_GNT,
        ST_REL
    } state_t;

    localparam int PSUM_W = 32;
    localparam logic signed [PSUM_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [PSUM_W-1:0] SAT_MIN = 32'sh8000_0000;

    // psum words are 4 bytes wide, so the word index becomes a byte address by shifting.
    localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/psum_sat_add.sv
// Combinational saturating signed adder for psum accumulation.
// The sum is formed one bit wider, then clamped when the extra bit disagrees with the sign bit.
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum,
    output logic                         ovf
);

    logic signed [DATA_WIDTH:0] wide;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] w);
        if (w[DATA_WIDTH] == w[DATA_WIDTH-1]) begin
            return w[DATA_WIDTH-1:0];
        end else if (w[DATA_WIDTH]) begin
            return DATA_WIDTH'(SAT_MIN);
        end else begin
            return DATA_WIDTH'(SAT_MAX);
        end
    endfunction

    assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign ovf  = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
    assign sum  = sat(wide);

endmodule

// File: rtl/psum_accum_ctrl.sv
// PL-side sequencer for the psum BRAM mux: read-modify-write accumulation, range clear,
// and arbitration of BRAM ownership between the PL datapath and the PS AXI BRAM controller.
module psum_accum_ctrl
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int IDX_WIDTH  = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_psum_vld,
    output logic                  o_psum_rdy,
    input  logic [IDX_WIDTH-1:0]  i_psum_idx,
    input  logic [DATA_WIDTH-1:0] i_psum_dat,
    input  logic                  i_psum_first,
    input  logic                  i_clr_start,
    input  logic [IDX_WIDTH-1:0]  i_clr_len,
    output logic                  o_clr_done,
    input  logic                  i_ps_req,
    output logic                  o_ps_gnt,
    output logic                  o_psenb,
    output logic                  o_busy,
    output logic                  o_sat,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idat,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    output logic [NUM_BYTE-1:0]   mem_wren,
    output logic                  mem_enb,
    output logic                  mem_rst
);

    state_t                       state, state_nxt;
    logic [IDX_WIDTH-1:0]         idx_p0;
    logic signed [DATA_WIDTH-1:0] dat_p0;
    logic                         first_p0;
    logic [IDX_WIDTH-1:0]         cnt_q, len_q;
    logic [IDX_WIDTH:0]           cnt_inc;
    logic signed [DATA_WIDTH-1:0] acc_sum;
    logic                         acc_ovf;
    logic                         sat_q;
    logic                         psum_fire, clr_go;
    logic                         mem_enb_nxt;
    logic [NUM_BYTE-1:0]          mem_wren_nxt;
    logic [ADDR_WIDTH-1:0]        mem_addr_nxt;
    logic [DATA_WIDTH-1:0]        mem_idat_nxt;

    function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [IDX_WIDTH-1:0] idx);
        return ADDR_WIDTH'(idx) << ADDR_SHIFT;
    endfunction

    assign o_psum_rdy = (state == ST_IDLE) && !i_ps_req && !i_clr_start && !rst;
    assign psum_fire  = i_psum_vld && o_psum_rdy;
    assign clr_go     = (state == ST_IDLE) && !i_ps_req && i_clr_start;
    assign cnt_inc    = {1'b0, cnt_q} + (IDX_WIDTH+1)'(1);

    assign o_clr_done = (state == ST_CLR) && (cnt_q == len_q);
    assign o_busy     = (state != ST_IDLE);
    assign o_ps_gnt   = (state == ST_GNT);
    assign o_psenb    = (state == ST_GNT);
    assign o_sat      = sat_q;
    assign mem_rst    = rst;

    psum_sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
        .a   ($signed(mem_odat)),
        .b   (dat_p0),
        .sum (acc_sum),
        .ovf (acc_ovf)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_ps_req)         state_nxt = ST_GNT;
                else if (i_clr_start) state_nxt = ST_CLR;
                else if (psum_fire)   state_nxt = i_psum_first ? ST_WR : ST_RD;
            end
            ST_RD:   state_nxt = (RD_LAT == 2) ? ST_WAIT : ST_WR;
            ST_WAIT: state_nxt = ST_WR;
            ST_WR:   state_nxt = ST_IDLE;
            ST_CLR:  if (cnt_q == len_q) state_nxt = ST_IDLE;
            ST_GNT:  if (!i_ps_req) state_nxt = ST_REL;
            ST_REL:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reads and clear writes are loaded on entry so they appear in their own state; the
    // accumulate write needs mem_odat from the WR cycle, so it lands on the bus one cycle later.
    always_comb begin
        mem_enb_nxt  = 1'b0;
        mem_wren_nxt = '0;
        mem_addr_nxt = mem_addr;
        mem_idat_nxt = mem_idat;
        unique case (state)
            ST_IDLE: begin
                if (clr_go) begin
                    if (i_clr_len != '0) begin
                        mem_enb_nxt  = 1'b1;
                        mem_wren_nxt = '1;
                        mem_addr_nxt = '0;
                        mem_idat_nxt = '0;
                    end
                end else if (psum_fire && !i_psum_first) begin
                    mem_enb_nxt  = 1'b1;
                    mem_addr_nxt = byte_addr(i_psum_idx);
                end
            end
            ST_WR: begin
                mem_enb_nxt  = 1'b1;
                mem_wren_nxt = '1;
                mem_addr_nxt = byte_addr(idx_p0);
                mem_idat_nxt = first_p0 ? dat_p0 : acc_sum;
            end
            ST_CLR: begin
                if (cnt_inc < {1'b0, len_q}) begin
                    mem_enb_nxt  = 1'b1;
                    mem_wren_nxt = '1;
                    mem_addr_nxt = byte_addr(cnt_inc[IDX_WIDTH-1:0]);
                    mem_idat_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Stage p0: accepted psum held for the duration of its read-modify-write.
    always_ff @(posedge clk) begin
        if (psum_fire) begin
            idx_p0   <= i_psum_idx;
            dat_p0   <= i_psum_dat;
            first_p0 <= i_psum_first;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            sat_q    <= 1'b0;
            mem_enb  <= 1'b0;
            mem_wren <= '0;
            mem_addr <= '0;
            mem_idat <= '0;
        end else begin
            state    <= state_nxt;
            mem_enb  <= mem_enb_nxt;
            mem_wren <= mem_wren_nxt;
            mem_addr <= mem_addr_nxt;
            mem_idat <= mem_idat_nxt;
            if (clr_go) begin
                cnt_q <= '0;
                len_q <= i_clr_len;
            end else if (state == ST_CLR && cnt_q != len_q) begin
                cnt_q <= cnt_q + IDX_WIDTH'(1);
            end
            if (i_clr_start) begin
                sat_q <= 1'b0;
            end else if (state == ST_WR && !first_p0 && acc_ovf) begin
                sat_q <= 1'b1;
            end
        end
    end

endmodule
